// File: rtl/router_out_fifo.sv
// router_out_fifo: per-destination output buffer of the 1x3 router.
// Stores header-tagged bytes, presents registered read data, marks the last
// byte of each packet with eop, and flushes itself (soft_reset) when the
// destination leaves data unread for TIMEOUT consecutive cycles.
// The packet length field is data[7:2], so WIDTH must be at least 8.
module router_out_fifo #(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 30
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             empty,
  output logic             full,
  output logic             eop,
  output logic             soft_reset
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Storage: bit WIDTH carries the header marker captured at write time.
  logic [WIDTH:0] mem [DEPTH];

  logic [AW:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      rd_ptr_reg, rd_ptr_next;
  logic [WIDTH-1:0] data_out_reg, data_out_next;
  logic             eop_reg, eop_next;
  logic             soft_reset_reg, soft_reset_next;
  logic [6:0]       pcnt_reg, pcnt_next;
  logic [TW-1:0]    tcnt_reg, tcnt_next;
  logic [WIDTH:0]   rd_word;
  logic             wr_acc, rd_acc;

  // Flags come from the pointer registers only; the extra MSB separates full from empty.
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign valid_out = !empty;
  assign data_out  = data_out_reg;
  assign eop       = eop_reg;
  assign soft_reset = soft_reset_reg;

  // A flush cycle ignores both ports.
  assign wr_acc  = write_enb && !full  && !soft_reset_reg;
  assign rd_acc  = read_enb  && !empty && !soft_reset_reg;
  assign rd_word = mem[rd_ptr_reg[AW-1:0]];

  // Storage write port; contents need no reset since the pointers define validity.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem[wr_ptr_reg[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  // Next-state for pointers, read data, packet framing and the unread-cycle timer.
  always_comb begin
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    data_out_next   = data_out_reg;
    pcnt_next       = pcnt_reg;
    eop_next        = 1'b0;
    tcnt_next       = '0;
    soft_reset_next = 1'b0;

    if (soft_reset_reg) begin
      // Flush: everything returns to its reset value at the end of this cycle.
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      data_out_next = '0;
      pcnt_next     = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
      end

      if (rd_acc) begin
        rd_ptr_next   = rd_ptr_reg + PTR_ONE;
        data_out_next = rd_word[WIDTH-1:0];
        if (rd_word[WIDTH]) begin
          // Header: payload length plus the trailing parity byte. Reloading
          // here silently abandons any packet that was still in progress.
          pcnt_next = {1'b0, rd_word[7:2]} + 7'd1;
        end else if (pcnt_reg != 7'd0) begin
          pcnt_next = pcnt_reg - 7'd1;
          eop_next  = (pcnt_reg == 7'd1);
        end
      end

      // Timer runs only while data sits unread; the pulse fires on the
      // TIMEOUT-th qualifying cycle and the following flush clears the timer.
      if (!empty && !read_enb) begin
        tcnt_next       = tcnt_reg + TW'(1);
        soft_reset_next = (tcnt_reg == TLAST);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      data_out_reg   <= '0;
      pcnt_reg       <= '0;
      eop_reg        <= 1'b0;
      tcnt_reg       <= '0;
      soft_reset_reg <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      data_out_reg   <= data_out_next;
      pcnt_reg       <= pcnt_next;
      eop_reg        <= eop_next;
      tcnt_reg       <= tcnt_next;
      soft_reset_reg <= soft_reset_next;
    end
  end

endmodule
